// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour type and counter helpers for vga_sync_gen.
package vga_pkg;

    localparam int CLK_DIV_DEF   = 4;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W   = 10;
    localparam int RED_W   = 3;
    localparam int GREEN_W = 3;
    localparam int BLUE_W  = 2;
    localparam int RGB_W   = RED_W + GREEN_W + BLUE_W;

    typedef struct packed {
        logic [RED_W-1:0]   r;
        logic [GREEN_W-1:0] g;
        logic [BLUE_W-1:0]  b;
    } rgb_t;

    function automatic logic in_range(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_test_pattern.sv
// Eight vertical colour bars across the visible width; bar index bits select R, G and B.
module vga_test_pattern
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF
) (
    input  logic [CNT_W-1:0] pixel_x,
    output logic [RGB_W-1:0] rgb
);

    localparam int BAR_W = H_VISIBLE / 8;

    logic [2:0] w_bar;
    rgb_t       w_colour;

    assign w_bar = 3'((pixel_x / CNT_W'(BAR_W)) % CNT_W'(8));

    always_comb begin
        w_colour.r = {RED_W{w_bar[2]}};
        w_colour.g = {GREEN_W{w_bar[1]}};
        w_colour.b = {BLUE_W{w_bar[0]}};
    end

    assign rgb = w_colour;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters and registered sync/colour decode.
// Define VGA_TEST_PATTERN_EN to replace rgb_in with the built-in colour-bar pattern.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             frame_start,
    output logic             Hsync,
    output logic             Vsync,
    output logic [2:0]       vgaRed,
    output logic [2:0]       vgaGreen,
    output logic [1:0]       vgaBlue
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_run;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_tick;
    logic             r_frame;
    logic             r_video;
    logic             r_hs;
    logic             r_vs;
    rgb_t             r_rgb;

    logic [DIV_W-1:0] w_div_next;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_tick_next;
    logic             w_frame_next;
    logic             w_video_next;
    logic [RGB_W-1:0] w_src;
    rgb_t             w_rgb_next;

`ifdef VGA_TEST_PATTERN_EN
    logic [RGB_W-1:0] w_pattern;

    vga_test_pattern #(
        .H_VISIBLE (H_VISIBLE)
    ) u_pattern (
        .pixel_x (w_h_next),
        .rgb     (w_pattern)
    );

    assign w_src = w_pattern;
`else
    assign w_src = rgb_in;
`endif

    // Every output flop is loaded from the next-state counts so decodes line up with pixel_x/pixel_y.
    // The divider holds at 0 for the first clock after reset so the first tick lands CLK_DIV clocks later.
    always_comb begin
        w_div_next = r_div;
        w_h_next   = r_h;
        w_v_next   = r_v;
        if (r_run) begin
            w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        end
        if (r_tick) begin
            if (r_h == H_LAST) begin
                w_h_next = '0;
                w_v_next = (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
            end else begin
                w_h_next = r_h + CNT_W'(1);
            end
        end
        w_tick_next  = (w_div_next == DIV_LAST);
        w_frame_next = w_tick_next && (w_h_next == H_LAST) && (w_v_next == V_LAST);
        w_video_next = (w_h_next < H_VIS) && (w_v_next < V_VIS);
        w_rgb_next   = w_video_next ? rgb_t'(w_src) : rgb_t'('0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_run   <= 1'b0;
            r_h     <= '0;
            r_v     <= '0;
            r_tick  <= 1'b0;
            r_frame <= 1'b0;
            r_video <= 1'b0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_rgb   <= '0;
        end else begin
            r_div   <= w_div_next;
            r_run   <= 1'b1;
            r_h     <= w_h_next;
            r_v     <= w_v_next;
            r_tick  <= w_tick_next;
            r_frame <= w_frame_next;
            r_video <= w_video_next;
            r_hs    <= !in_range(w_h_next, HS_FIRST, HS_LAST);
            r_vs    <= !in_range(w_v_next, VS_FIRST, VS_LAST);
            r_rgb   <= w_rgb_next;
        end
    end

    assign pixel_tick  = r_tick;
    assign pixel_x     = r_h;
    assign pixel_y     = r_v;
    assign video_on    = r_video;
    assign frame_start = r_frame;
    assign Hsync       = r_hs;
    assign Vsync       = r_vs;
    assign vgaRed      = r_rgb.r;
    assign vgaGreen    = r_rgb.g;
    assign vgaBlue     = r_rgb.b;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using a shrunken 24x10 raster so whole frames fit a short run.
module tb_vga_sync_gen;

    localparam int DIV = 4;
    localparam int HV = 16, HFP = 2, HS = 4, HBP = 2;
    localparam int VV = 6, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = 24;
    localparam int VT = 10;
    localparam int FRAME_CLKS = HT * VT * DIV;

    logic       clk;
    logic       reset;
    logic [7:0] rgb_in;
    logic       pixel_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       frame_start;
    logic       Hsync;
    logic       Vsync;
    logic [2:0] vgaRed;
    logic [2:0] vgaGreen;
    logic [1:0] vgaBlue;

    int n_tests = 0;
    int n_fail  = 0;
    int k_cnt   = 0;
    int n_frame = 0;
    int n_hs_low_line0 = 0;

    vga_sync_gen #(
        .CLK_DIV (DIV),
        .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rgb_in      (rgb_in),
        .pixel_tick  (pixel_tick),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .frame_start (frame_start),
        .Hsync       (Hsync),
        .Vsync       (Vsync),
        .vgaRed      (vgaRed),
        .vgaGreen    (vgaGreen),
        .vgaBlue     (vgaBlue)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_x", 32'(pixel_x), 0);
        chk("rst_y", 32'(pixel_y), 0);
        chk("rst_tick", 32'(pixel_tick), 0);
        chk("rst_frame", 32'(frame_start), 0);
        chk("rst_video", 32'(video_on), 0);
        chk("rst_hsync", 32'(Hsync), 1);
        chk("rst_vsync", 32'(Vsync), 1);
        chk("rst_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 0);
    endtask

    // Drives one clock of colour input, then checks every output against the
    // closed-form position k_cnt clocks after reset release.
    task automatic run_clocks(input int n);
        int k, p, ex, ey, bar;
        logic [7:0] drv, e_rgb;
        logic e_tick, e_frame, e_video, e_hs, e_vs;
        for (int i = 0; i < n; i++) begin
            drv = (k_cnt < FRAME_CLKS) ? 8'hFF : 8'($urandom_range(0, 255));
            rgb_in = drv;
            @(posedge clk);
            @(negedge clk);
            k       = k_cnt;
            p       = k / DIV;
            ex      = p % HT;
            ey      = (p / HT) % VT;
            e_tick  = (k % DIV) == DIV - 1;
            e_frame = e_tick && ((p % (HT * VT)) == HT * VT - 1);
            e_video = (ex < HV) && (ey < VV);
            e_hs    = !((ex >= HV + HFP) && (ex <= HV + HFP + HS - 1));
            e_vs    = !((ey >= VV + VFP) && (ey <= VV + VFP + VS - 1));
`ifdef VGA_TEST_PATTERN_EN
            bar   = ex / (HV / 8);
            e_rgb = {(bar & 4) != 0 ? 3'b111 : 3'b000,
                     (bar & 2) != 0 ? 3'b111 : 3'b000,
                     (bar & 1) != 0 ? 2'b11 : 2'b00};
`else
            bar   = 0;
            e_rgb = drv;
`endif
            if (!e_video) e_rgb = 8'h00;
            chk("x", 32'(pixel_x), 32'(ex));
            chk("y", 32'(pixel_y), 32'(ey));
            chk("tick", 32'(pixel_tick), 32'(e_tick));
            chk("frame", 32'(frame_start), 32'(e_frame));
            chk("video", 32'(video_on), 32'(e_video));
            chk("hsync", 32'(Hsync), 32'(e_hs));
            chk("vsync", 32'(Vsync), 32'(e_vs));
            chk("rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'(e_rgb));
            if (frame_start) n_frame++;
            if (!Hsync && k < HT * DIV) n_hs_low_line0++;
            k_cnt++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        rgb_in = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state();

        // Release: first clock at (0,0) visible, first tick on clock DIV, x steps after it.
        reset = 1'b0;
        run_clocks(DIV + 1);
        chk("first_x_after_tick", 32'(pixel_x), 1);

        // Two full frames plus the walk to (20,7), inside both sync pulses.
        run_clocks(2673 - (DIV + 1));
        chk("pre_rst_x", 32'(pixel_x), 20);
        chk("pre_rst_y", 32'(pixel_y), 7);
        chk("pre_rst_hsync", 32'(Hsync), 0);
        chk("pre_rst_vsync", 32'(Vsync), 0);
        chk("frame_count", 32'(n_frame), 2);
        chk("hsync_low_clks_line0", 32'(n_hs_low_line0), HS * DIV);

        // One-clock mid-frame reset, then the restart sequence again.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_state();
        reset = 1'b0;
        k_cnt = 0;
        run_clocks(3 * DIV);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
